// File: rtl/rt_fetch_pkg.sv
// Shared types and constants for the RT-core instruction fetch stage.
package rt_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } fetch_entry_t;

  localparam logic [15:0] INST_BYTES = 16'd2;

endpackage

// File: rtl/rt_fetch_queue.sv
// First-word-fall-through instruction queue holding {pc, data} pairs for the decoder.
module rt_fetch_queue
  import rt_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     head_valid_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != FULL) || do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is forced to zero while empty so stale entries never leak to the decoder.
  always_comb begin
    count_o      = count_q;
    head_valid_o = (count_q != '0);
    head_o       = head_valid_o ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: rtl/rt_fetch_unit.sv
// RT-core fetch stage: one outstanding I-cache request, FWFT instruction queue,
// redirect handling with discard of a response that cannot be withdrawn.
module rt_fetch_unit
  import rt_fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic                          clk_rt_50mhz,
  input  logic                          rst_n,
  input  logic                          fetch_enable,
  input  logic                          redirect_valid,
  input  logic [15:0]                   redirect_pc,
  output logic                          ic_req,
  output logic [15:0]                   ic_addr,
  input  logic [15:0]                   ic_data,
  input  logic                          ic_ready,
  input  logic                          ic_hit,
  output logic                          inst_valid,
  output logic [15:0]                   inst_data,
  output logic [15:0]                   inst_pc,
  input  logic                          inst_ready,
  output logic [15:0]                   fetch_pc,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   miss_fetches
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] QFULL = QUEUE_DEPTH[CW-1:0];

  fetch_state_t  state_q;
  logic          ic_req_q;
  logic [15:0]   ic_addr_q;
  logic [15:0]   fetch_pc_q;
  logic [31:0]   stall_q;
  logic [31:0]   miss_q;

  logic [15:0]   redirect_target;
  logic          issue_ok;
  logic          push;
  logic          pop;
  logic          stall_tick;
  logic          miss_tick;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          head_valid;

  always_comb begin
    redirect_target = redirect_pc & 16'hFFFE;
    issue_ok        = fetch_enable && (count < QFULL) && !redirect_valid;
    push            = (state_q == S_REQ) && ic_ready && !redirect_valid;
    pop             = head_valid && inst_ready;
    stall_tick      = (state_q != S_IDLE) && !ic_ready;
    miss_tick       = push && !ic_hit;
    push_entry      = '{pc: fetch_pc_q, data: ic_data};
  end

  rt_fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk_i        (clk_rt_50mhz),
    .rst_n_i      (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ic_req_q   <= 1'b0;
      ic_addr_q  <= '0;
      fetch_pc_q <= RESET_PC;
      stall_q    <= '0;
      miss_q     <= '0;
    end else begin
      if (stall_tick && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (miss_tick && (miss_q != '1))   miss_q  <= miss_q + 32'd1;

      unique case (state_q)
        S_IDLE: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_target;
          end else if (issue_ok) begin
            state_q   <= S_REQ;
            ic_req_q  <= 1'b1;
            ic_addr_q <= fetch_pc_q;
          end
        end
        S_REQ: begin
          // A redirect cannot withdraw the request; the reply is dropped instead.
          if (redirect_valid) begin
            fetch_pc_q <= redirect_target;
            if (ic_ready) begin
              state_q  <= S_IDLE;
              ic_req_q <= 1'b0;
            end else begin
              state_q  <= S_DISCARD;
            end
          end else if (ic_ready) begin
            fetch_pc_q <= fetch_pc_q + INST_BYTES;
            state_q    <= S_IDLE;
            ic_req_q   <= 1'b0;
          end
        end
        S_DISCARD: begin
          if (redirect_valid) fetch_pc_q <= redirect_target;
          if (ic_ready) begin
            state_q  <= S_IDLE;
            ic_req_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ic_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ic_req       = ic_req_q;
    ic_addr      = ic_addr_q;
    fetch_pc     = fetch_pc_q;
    queue_count  = count;
    inst_valid   = head_valid;
    inst_data    = head.data;
    inst_pc      = head.pc;
    stall_cycles = stall_q;
    miss_fetches = miss_q;
  end

endmodule

// File: doc/rt_fetch_unit.md
Name: rt_fetch_unit

Overview:
RT-core instruction fetch stage, directly upstream of rt_icache_controller; drives its cpu_req/cpu_addr and consumes cpu_data/cpu_ready/cpu_hit.
Holds the PC and issues one cache request at a time.
Buffers returned instructions with their PCs in a small FIFO for the decoder.
Handles branch/interrupt redirects, including discarding an in-flight response that cannot be aborted.

Parameters:
QUEUE_DEPTH, 4, instruction queue entries (power of 2, >=2)
RESET_PC, 16'h0000, first fetch address after reset (bit 0 must be 0)

Ports:
clk_rt_50mhz  in  1  RT-core clock, 50 MHz
rst_n  in  1  asynchronous, active-low reset
fetch_enable  in  1  permits new cache requests when high
redirect_valid  in  1  one-cycle pulse: flush queue, load new PC
redirect_pc  in  16  redirect target; bit 0 ignored (forced 0)
ic_req  out  1  to cache cpu_req
ic_addr  out  16  to cache cpu_addr (byte address, even)
ic_data  in  16  from cache cpu_data, valid when ic_ready
ic_ready  in  1  from cache cpu_ready
ic_hit  in  1  from cache cpu_hit
inst_valid  out  1  queue head valid
inst_data  out  16  queue head instruction
inst_pc  out  16  queue head PC
inst_ready  in  1  decoder accepts head
fetch_pc  out  16  next PC to be requested
queue_count  out  $clog2(QUEUE_DEPTH)+1  entries held
stall_cycles  out  32  cycles spent waiting on cache (saturating)
miss_fetches  out  32  accepted responses with ic_hit=0 (saturating)

Behaviour:
- Reset (async, immediate): state S_IDLE; ic_req=0; ic_addr=0; fetch_pc=RESET_PC; queue empty; inst_valid=0; inst_data=0; inst_pc=0; counters=0.
- FSM states: S_IDLE, S_REQ, S_DISCARD.
- S_IDLE -> S_REQ at an edge when fetch_enable && queue_count<QUEUE_DEPTH && !redirect_valid.
  - ic_req=1 and ic_addr=fetch_pc are registered at that edge.
- S_REQ: ic_req and ic_addr held stable until ic_ready is sampled high.
  - On ready: push {fetch_pc, ic_data}; fetch_pc += 2 (16-bit wrap, 0xFFFE -> 0x0000); ic_req=0; go to S_IDLE.
  - This gives a mandatory one-cycle ic_req gap between requests, matching the cache handshake.
- One request outstanding maximum. The issue check against queue_count guarantees a free slot at push.
- Redirect in S_IDLE: queue flushed; fetch_pc={redirect_pc[15:1],0}; stay in S_IDLE that cycle.
- Redirect in S_REQ without ic_ready: queue flushed; fetch_pc loaded; go to S_DISCARD.
  - ic_req and ic_addr stay unchanged, because the cache request cannot be withdrawn.
- S_DISCARD: on ic_ready, drop the data (no push, no miss count); go to S_IDLE.
- Redirect in the same cycle as ic_ready (S_REQ or S_DISCARD): response dropped; queue flushed; fetch_pc=target; go to S_IDLE.
- Redirect in S_DISCARD: fetch_pc is reloaded with the newer target.
- Queue is first-word-fall-through:
  - inst_valid = (count!=0).
  - A pop occurs when inst_valid && inst_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Flush overrides both push and pop.
  - The first pushed instruction appears on inst_valid the cycle after the ic_ready edge.
- fetch_enable low does not cancel an outstanding request; it only blocks new issues.
- stall_cycles: +1 each cycle in S_REQ or S_DISCARD with ic_ready=0; saturates at 0xFFFFFFFF.
- miss_fetches: +1 per pushed response with ic_hit=0; saturates.

Decomposition:
- Package rt_fetch_pkg: fetch_state_t enum, fetch_entry_t struct {pc[15:0], data[15:0]}, INST_BYTES=2 constant.
- Sub-module rt_fetch_queue: parameterised synchronous FWFT FIFO with push, pop, flush, count, head outputs.

Test Plan:
1. Reset, fetch_enable=1, inst_ready=1, cache model returns ready 1 cycle after req with data=addr+16'h1000 -> ic_addr sequence 0x0000, 0x0002, 0x0004 with one-cycle req gaps; decoder sees (0x0000,0x1000), (0x0002,0x1002).
2. inst_ready=0 -> queue_count reaches 4, ic_req stays 0, fetch_pc=0x0008. Then inst_ready=1 -> fetching resumes at 0x0008.
3. Cache latency 5; redirect_pc=0x3000 pulsed in the 2nd cycle of S_REQ -> ic_addr held stable until ready; response not pushed; queue_count=0 the cycle after redirect; next ic_addr=0x3000.
4. redirect_pc=0x4001 -> next ic_addr=0x4000, inst_pc=0x4000.
5. redirect_pc=0xFFFC -> ic_addr sequence 0xFFFC, 0xFFFE, 0x0000.
6. Cache latency 3 with ic_hit=0 for one request -> stall_cycles increases by 3, miss_fetches by 1.
   Assert rst_n low mid-request -> ic_req=0 immediately, queue_count=0.
